// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and fetch queue feeding decode over valid/ready
// Optional fetch counter built only when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_WORDS   = 128,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [31:0] PC,
    input  logic [31:0] Instr,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Halt,
    input  logic        DecReady,
    output logic        DecValid,
    output logic [31:0] DecInstr,
    output logic [31:0] DecPC,
    output logic        FetchFault,
    output logic [31:0] FetchCount
);

    localparam logic [31:0] MAX_PC = 32'(4 * MEM_WORDS - 4);
    localparam logic [2:0]  DEPTH  = 3'(QUEUE_DEPTH);
    localparam logic [1:0]  LAST   = 2'(QUEUE_DEPTH - 1);

    typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0] qi_q [4];
    logic [31:0] qi_d [4];
    logic [31:0] qp_q [4];
    logic [31:0] qp_d [4];

    logic in_range, fetch_fault, dec_valid, deq, space, attempt, enq;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        fetch_fault = (state_q == ST_FAULT);
        in_range    = (pc_q <= MAX_PC);
        dec_valid   = (count_q != 3'd0) && !Redirect;
        deq         = dec_valid && DecReady;
        space       = (count_q < DEPTH) || deq;
        attempt     = !Redirect && !Halt && !fetch_fault && space;
        enq         = attempt && in_range;
    end

    // Fault is sticky until a redirect; halt/backpressure only decide RUN vs STALL.
    always_comb begin
        state_d = state_q;
        if (Redirect)
            state_d = ST_RUN;
        else if (fetch_fault || (attempt && !in_range))
            state_d = ST_FAULT;
        else if (Halt || !space)
            state_d = ST_STALL;
        else
            state_d = ST_RUN;
    end

    always_comb begin
        qi_d     = qi_q;
        qp_d     = qp_q;
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (Redirect) begin
            pc_d     = RedirectPC & 32'hFFFF_FFFC;
            count_d  = 3'd0;
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
        end else begin
            if (enq) begin
                qi_d[wr_ptr_q] = Instr;
                qp_d[wr_ptr_q] = pc_q;
                wr_ptr_d       = ptr_inc(wr_ptr_q);
                pc_d           = pc_q + 32'd4;
            end
            if (deq)
                rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + {2'b00, enq} - {2'b00, deq};
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            count_q  <= 3'd0;
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                qi_q[i] <= 32'h0;
                qp_q[i] <= 32'h0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            qi_q     <= qi_d;
            qp_q     <= qp_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt_q, fcnt_d;

    always_comb begin
        fcnt_d = fcnt_q + {31'h0, enq};
    end

    always_ff @(posedge CLK) begin
        if (Reset)
            fcnt_q <= 32'h0;
        else
            fcnt_q <= fcnt_d;
    end

    assign FetchCount = fcnt_q;
`else
    assign FetchCount = 32'h0;
`endif

    assign PC         = pc_q;
    assign DecValid   = dec_valid;
    assign DecInstr   = (count_q != 3'd0) ? qi_q[rd_ptr_q] : 32'h0;
    assign DecPC      = (count_q != 3'd0) ? qp_q[rd_ptr_q] : 32'h0;
    assign FetchFault = fetch_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized and directed bench for instr_fetch_unit with a queue-based model
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC    = 32'h0;
    localparam int          MEM_WORDS   = 128;
    localparam int          QUEUE_DEPTH = 2;
    localparam logic [31:0] MAX_PC      = 32'h1FC;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = 32'h0;
    logic        Halt = 1'b0;
    logic        DecReady = 1'b0;
    logic        DecValid;
    logic [31:0] DecInstr;
    logic [31:0] DecPC;
    logic        FetchFault;
    logic [31:0] FetchCount;

    logic [31:0] mem [MEM_WORDS];
    assign Instr = mem[PC[8:2]];

    always #5 CLK = ~CLK;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .MEM_WORDS  (MEM_WORDS),
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .PC        (PC),
        .Instr     (Instr),
        .Redirect  (Redirect),
        .RedirectPC(RedirectPC),
        .Halt      (Halt),
        .DecReady  (DecReady),
        .DecValid  (DecValid),
        .DecInstr  (DecInstr),
        .DecPC     (DecPC),
        .FetchFault(FetchFault),
        .FetchCount(FetchCount)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc = 32'h0;
    logic        m_fault = 1'b0;
    logic [31:0] m_cnt = 32'h0;
    int          ncmp = 0;
    int          nfail = 0;
    logic [31:0] seen_pc[$];
    logic [31:0] seen_in[$];
    logic [31:0] prog [4] = '{32'hE200_0000, 32'hE590_1001, 32'hE590_2002, 32'hE590_3003};

    wire [129:0] obs_vec = {DecValid, DecPC, DecInstr, PC, FetchFault, FetchCount};

    function automatic logic [31:0] exp_cnt();
`ifdef FETCH_PERF_CNT_EN
        return m_cnt;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [129:0] exp_vec();
        logic        v;
        logic [31:0] hp, hi;
        v  = (mq.size() != 0) && !Redirect;
        hp = (mq.size() != 0) ? mq[0].pc : 32'h0;
        hi = (mq.size() != 0) ? mq[0].instr : 32'h0;
        return {v, hp, hi, m_pc, m_fault, exp_cnt()};
    endfunction

    task automatic model_update();
        bit deq, space;
        if (Reset) begin
            mq.delete();
            m_pc    = RESET_PC;
            m_fault = 1'b0;
            m_cnt   = 32'h0;
        end else if (Redirect) begin
            mq.delete();
            m_pc    = RedirectPC & 32'hFFFF_FFFC;
            m_fault = 1'b0;
        end else begin
            deq   = (mq.size() != 0) && DecReady;
            space = (mq.size() < QUEUE_DEPTH) || deq;
            if (deq)
                void'(mq.pop_front());
            if (!Halt && !m_fault && space) begin
                if (m_pc <= MAX_PC) begin
                    mq.push_back({mem[m_pc[8:2]], m_pc});
                    m_pc  = m_pc + 32'd4;
                    m_cnt = m_cnt + 32'd1;
                end else begin
                    m_fault = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic rd, input logic hl, input logic rdir, input logic [31:0] rpc);
        DecReady   = rd;
        Halt       = hl;
        Redirect   = rdir;
        RedirectPC = rpc;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        ncmp++;
        if (obs_vec !== {1'b0, 32'h0, 32'h0, RESET_PC, 1'b0, 32'h0}) begin
            nfail++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec, {1'b0, 32'h0, 32'h0, RESET_PC, 1'b0, 32'h0});
        end
        Reset = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            ncmp++;
            if (obs_vec !== {1'b0, 32'h0, 32'h0, RESET_PC, 1'b0, 32'h0}) begin
                nfail++;
                $display("FAIL reset_held cyc=%0d got=%h", i, obs_vec);
            end
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_sequential();
        int first_valid;
        first_valid = -1;
        seen_pc.delete();
        seen_in.delete();
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #2;
            ncmp++;
            if (obs_vec !== exp_vec()) begin
                nfail++;
                $display("FAIL seq_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
            end
            if (DecValid) begin
                if (first_valid < 0) first_valid = i;
                seen_pc.push_back(DecPC);
                seen_in.push_back(DecInstr);
            end
            tick();
        end
        ncmp++;
        if (first_valid != 1) begin
            nfail++;
            $display("FAIL seq_first_valid got=%0d exp=1", first_valid);
        end
        for (int k = 0; k < 4; k++) begin
            ncmp++;
            if (seen_pc.size() <= k || seen_pc[k] !== 32'(4 * k) || seen_in[k] !== prog[k]) begin
                nfail++;
                $display("FAIL seq_order idx=%0d got_pc=%h got_instr=%h exp_pc=%h exp_instr=%h",
                         k, (seen_pc.size() > k) ? seen_pc[k] : 32'hx,
                         (seen_in.size() > k) ? seen_in[k] : 32'hx, 32'(4 * k), prog[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        seen_pc.delete();
        do_reset();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #2;
            ncmp++;
            if (obs_vec !== exp_vec()) begin
                nfail++;
                $display("FAIL bp_stall_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
            end
            tick();
        end
        #2;
        ncmp++;
        if (PC !== 32'h8 || DecInstr !== 32'hE200_0000 || DecValid !== 1'b1) begin
            nfail++;
            $display("FAIL bp_saturate got_pc=%h got_instr=%h got_valid=%b exp_pc=8 exp_instr=e2000000 exp_valid=1",
                     PC, DecInstr, DecValid);
        end
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #2;
            ncmp++;
            if (obs_vec !== exp_vec()) begin
                nfail++;
                $display("FAIL bp_drain_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
            end
            if (DecValid) seen_pc.push_back(DecPC);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            ncmp++;
            if (seen_pc.size() <= k || seen_pc[k] !== 32'(4 * k)) begin
                nfail++;
                $display("FAIL bp_drain_order idx=%0d got=%h exp=%h", k,
                         (seen_pc.size() > k) ? seen_pc[k] : 32'hx, 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        set_in(1'b0, 1'b0, 1'b1, 32'h57);
        #2;
        ncmp++;
        if (DecValid !== 1'b0 || obs_vec !== exp_vec()) begin
            nfail++;
            $display("FAIL redir_same_cycle got=%h exp=%h", obs_vec, exp_vec());
        end
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        ncmp++;
        if (PC !== 32'h54 || DecValid !== 1'b0) begin
            nfail++;
            $display("FAIL redir_pc got_pc=%h got_valid=%b exp_pc=54 exp_valid=0", PC, DecValid);
        end
        tick();
        #2;
        ncmp++;
        if (DecPC !== 32'h54 || DecValid !== 1'b1 || obs_vec !== exp_vec()) begin
            nfail++;
            $display("FAIL redir_first_fetch got=%h exp=%h", obs_vec, exp_vec());
        end
        tick();
    endtask

    task automatic test_fault();
        seen_pc.delete();
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 32'h1F8);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #2;
            ncmp++;
            if (obs_vec !== exp_vec()) begin
                nfail++;
                $display("FAIL fault_fill_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
            end
            tick();
        end
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #2;
            ncmp++;
            if (obs_vec !== exp_vec()) begin
                nfail++;
                $display("FAIL fault_drain_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
            end
            if (DecValid) seen_pc.push_back(DecPC);
            tick();
        end
        #2;
        ncmp++;
        if (FetchFault !== 1'b1 || PC !== 32'h200 || DecValid !== 1'b0 || seen_pc.size() != 2 ||
            seen_pc[0] !== 32'h1F8 || seen_pc[1] !== 32'h1FC) begin
            nfail++;
            $display("FAIL fault_set got_fault=%b got_pc=%h got_valid=%b drained=%0d exp_fault=1 exp_pc=200 exp_drained=2",
                     FetchFault, PC, DecValid, seen_pc.size());
        end
        set_in(1'b1, 1'b0, 1'b1, 32'h0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        ncmp++;
        if (FetchFault !== 1'b0 || PC !== 32'h0) begin
            nfail++;
            $display("FAIL fault_clear got_fault=%b got_pc=%h exp_fault=0 exp_pc=0", FetchFault, PC);
        end
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #2;
            ncmp++;
            if (obs_vec !== exp_vec()) begin
                nfail++;
                $display("FAIL halt_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
            end
            tick();
        end
        #2;
        ncmp++;
        if (PC !== 32'h8 || DecValid !== 1'b0) begin
            nfail++;
            $display("FAIL halt_hold got_pc=%h got_valid=%b exp_pc=8 exp_valid=0", PC, DecValid);
        end
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        #2;
        ncmp++;
        if (DecValid !== 1'b1 || DecPC !== 32'h8 || DecInstr !== prog[2]) begin
            nfail++;
            $display("FAIL halt_resume got_valid=%b got_pc=%h got_instr=%h exp_pc=8 exp_instr=%h",
                     DecValid, DecPC, DecInstr, prog[2]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = $urandom & 32'h1FF;
                1:       rpc = 32'h1E0 + $urandom_range(0, 31);
                2:       rpc = $urandom;
                default: rpc = 32'h1F8 | $urandom_range(0, 3);
            endcase
            set_in(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 12) == 0, rpc);
            Reset = (($urandom % 60) == 0);
            #2;
            ncmp++;
            if (obs_vec !== exp_vec()) begin
                nfail++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
            end
            tick();
        end
        Reset = 1'b0;
    endtask

    task automatic test_perf_count();
        int guard;
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        guard = 0;
        while (m_cnt < 10 && guard < 40) begin
            #2;
            ncmp++;
            if (obs_vec !== exp_vec()) begin
                nfail++;
                $display("FAIL perf_model cyc=%0d got=%h exp=%h", guard, obs_vec, exp_vec());
            end
            tick();
            guard++;
        end
        set_in(1'b1, 1'b0, 1'b1, 32'h40);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        while (m_cnt < 13 && guard < 80) begin
            tick();
            guard++;
        end
        #2;
        ncmp++;
`ifdef FETCH_PERF_CNT_EN
        if (FetchCount !== 32'd13 || m_cnt != 32'd13) begin
            nfail++;
            $display("FAIL perf_count got=%0d exp=13 (model=%0d)", FetchCount, m_cnt);
        end
`else
        if (FetchCount !== 32'd0 || m_cnt != 32'd13) begin
            nfail++;
            $display("FAIL perf_count got=%0d exp=0 (model=%0d)", FetchCount, m_cnt);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = prog[i];
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_fault();
        test_halt();
        test_random();
        test_perf_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
